// File: rtl/sum_of_powers_pkg.sv
// Shared types and constants for the sum-of-powers accumulator.
package sum_of_powers_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_LINEAR = 1'b0;
  localparam logic MODE_SQUARE = 1'b1;

endpackage

// File: rtl/sum_of_powers_ctrl.sv
// Control FSM for the sum-of-powers accumulator: sequences IDLE -> ACC -> DONE
// and produces the load/step strobes for the datapath.
//
// Handshake rule for both sides: a transfer happens on a rising edge where
// valid and ready are both high. in_ready is high only in IDLE and sum_valid
// only in DONE, so the request and result handshakes can never coincide.
import sum_of_powers_pkg::*;

module sum_of_powers_ctrl (
  input  logic   clk,
  input  logic   reset,
  input  logic   in_valid,
  input  logic   sum_ready,
  input  logic   n_zero,     // requested N is zero (skip ACC entirely)
  input  logic   last_add,   // the add happening this cycle is the final one
  output logic   in_ready,
  output logic   busy,
  output logic   sum_valid,
  output logic   load,       // capture a new request into the datapath
  output logic   step,       // perform one accumulate/iterate step
  output state_t state_o     // current state, for observation
);

  state_t state_q, state_d;

  // State register; asynchronous reset returns to IDLE at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = n_zero ? ST_DONE : ST_ACC;
        end
      end
      ST_ACC: begin
        step = 1'b1;
        if (last_add) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (sum_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake and status outputs depend only on the registered state.
  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_ACC);
  assign sum_valid = (state_q == ST_DONE);
  assign state_o   = state_q;

endmodule

// File: rtl/sum_of_powers_accum.sv
// Iterative accumulator producing sum(k) or sum(k^2) for k = 1..N using only
// an adder: k^2 is formed by adding k to the accumulator k times.
// Optional build macro SUM_OF_POWERS_SATURATE_EN: clamp the accumulator to
// all-ones on overflow instead of wrapping. Overflow is flagged either way.
import sum_of_powers_pkg::*;

module sum_of_powers_accum #(
  parameter int N_W   = 4,
  parameter int SUM_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_W-1:0]   N,
  input  logic             mode,
  output logic [SUM_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             overflow,
  output logic             busy
);

  if (SUM_W < N_W) begin : g_bad_width
    $error("sum_of_powers_accum: SUM_W must be >= N_W");
  end

  logic [N_W-1:0]   i_q, i_d;      // current term k
  logic [N_W-1:0]   j_q, j_d;      // repetition count of k within k^2
  logic [SUM_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             mode_q, mode_d;

  logic             load, step, advance, last_add;
  logic [SUM_W:0]   i_ext, sum_ext;
  state_t           fsm_state;

  // Linear mode moves to the next term every add; square mode repeats term
  // i exactly i times before moving on.
  assign advance  = (mode_q == MODE_LINEAR) || (j_q == i_q);
  assign last_add = (i_q == N_W'(1)) && advance;
  assign i_ext    = {{(SUM_W + 1 - N_W){1'b0}}, i_q};
  assign sum_ext  = {1'b0, acc_q} + i_ext;

  sum_of_powers_ctrl u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .sum_ready (sum_ready),
    .n_zero    (N == '0),
    .last_add  (last_add),
    .in_ready  (in_ready),
    .busy      (busy),
    .sum_valid (sum_valid),
    .load      (load),
    .step      (step),
    .state_o   (fsm_state)
  );

  // Datapath next-state: capture a request, or take one accumulate step.
  always_comb begin
    i_d    = i_q;
    j_d    = j_q;
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    mode_d = mode_q;
    if (load) begin
      i_d    = N;
      j_d    = N_W'(1);
      acc_d  = '0;
      ovf_d  = 1'b0;
      mode_d = mode;
    end else if (step) begin
      if (sum_ext[SUM_W]) ovf_d = 1'b1;
`ifdef SUM_OF_POWERS_SATURATE_EN
      // Once clamped the accumulator stays pinned for the rest of the run.
      if (sum_ext[SUM_W] || ovf_q) acc_d = '1;
      else                         acc_d = sum_ext[SUM_W-1:0];
`else
      acc_d = sum_ext[SUM_W-1:0];
`endif
      if (advance) begin
        i_d = i_q - N_W'(1);
        j_d = N_W'(1);
      end else begin
        j_d = j_q + N_W'(1);
      end
    end
  end

  // Datapath registers; reset discards any partial result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_q    <= '0;
      j_q    <= '0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      mode_q <= MODE_LINEAR;
    end else begin
      i_q    <= i_d;
      j_q    <= j_d;
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      mode_q <= mode_d;
    end
  end

  // Result outputs are presented only while the result is valid.
  assign sum      = (fsm_state == ST_DONE) ? acc_q : '0;
  assign overflow = (fsm_state == ST_DONE) ? ovf_q : 1'b0;

endmodule

// File: tb/tb_sum_of_powers_accum.sv
// Testbench for sum_of_powers_accum: a 12-bit result instance for the main
// scenarios and an 8-bit result instance for the overflow scenario.
module tb_sum_of_powers_accum;

  logic        clk;
  logic        reset;

  logic        in_valid, in_ready, mode_in, sum_valid, sum_ready, overflow, busy;
  logic [3:0]  n_in;
  logic [11:0] sum;

  logic        in_valid_b, in_ready_b, mode_b, sum_valid_b, sum_ready_b, overflow_b, busy_b;
  logic [3:0]  n_b;
  logic [7:0]  sum_b;

  int          n_checks;
  int          n_fail;
  logic [11:0] exp_sum;
  logic        exp_ovf;

  sum_of_powers_accum #(.N_W(4), .SUM_W(12)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .N(n_in), .mode(mode_in), .sum(sum), .sum_valid(sum_valid),
    .sum_ready(sum_ready), .overflow(overflow), .busy(busy)
  );

  sum_of_powers_accum #(.N_W(4), .SUM_W(8)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .N(n_b), .mode(mode_b), .sum(sum_b), .sum_valid(sum_valid_b),
    .sum_ready(sum_ready_b), .overflow(overflow_b), .busy(busy_b)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: the exact mathematical series value, no width limit.
  function automatic longint exact_sum(input int n, input int m);
    longint s;
    s = 0;
    for (int k = 1; k <= n; k++) s += (m == 1) ? longint'(k) * k : longint'(k);
    return s;
  endfunction

  // Reference for a SUM_W-bit result: wrap or clamp depending on the build.
  function automatic longint fit_sum(input longint exact, input int w);
    longint maxv;
    maxv = (longint'(1) << w) - 1;
`ifdef SUM_OF_POWERS_SATURATE_EN
    return (exact > maxv) ? maxv : exact;
`else
    return exact % (maxv + 1);
`endif
  endfunction

  // Issue one request on the 12-bit instance (caller is at a negedge) and
  // follow it until sum_valid, checking busy, latency, sum and overflow.
  task automatic issue(input int n, input int m);
    longint exact;
    int     len, k, w;
    bit     seen;
    exact   = exact_sum(n, m);
    len     = (m == 1) ? n * (n + 1) / 2 : n;
    exp_ovf = (exact > 4095);
    exp_sum = 12'(fit_sum(exact, 12));
    in_valid = 1'b1;
    n_in     = 4'(n);
    mode_in  = m[0];
    w = 0;
    while (in_ready !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    seen = 1'b0;
    while (!seen && k <= len + 4) begin
      if (sum_valid === 1'b1) begin
        seen = 1'b1;
      end else begin
        n_checks++;
        if (busy !== 1'(k <= len) || in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_cycle n=%0d m=%0d k=%0d: busy=%b in_ready=%b required busy=%b in_ready=0",
                   n, m, k, busy, in_ready, (k <= len));
        end
        @(negedge clk);
        k++;
      end
    end
    n_checks++;
    if (!seen || k != len + 1) begin
      n_fail++;
      $display("FAIL latency n=%0d m=%0d: sum_valid after %0d cycles (seen=%0b) required %0d",
               n, m, k, seen, len + 1);
    end
    n_checks++;
    if (sum !== exp_sum || overflow !== exp_ovf || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL result n=%0d m=%0d: sum=%0d ovf=%b busy=%b required sum=%0d ovf=%b busy=0",
               n, m, sum, overflow, busy, exp_sum, exp_ovf);
    end
  endtask

  // Hold the result for d further cycles (sum_ready low), then accept it and
  // check that the block is back in IDLE one cycle later.
  task automatic finish_result(input int d);
    for (int c = 0; c < d; c++) begin
      @(negedge clk);
      n_checks++;
      if (sum_valid !== 1'b1 || sum !== exp_sum || overflow !== exp_ovf || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold c=%0d: valid=%b sum=%0d ovf=%b in_ready=%b required 1/%0d/%b/0",
                 c, sum_valid, sum, overflow, in_ready, exp_sum, exp_ovf);
      end
    end
    sum_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || sum_valid !== 1'b0 || sum !== 12'd0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL release: in_ready=%b valid=%b sum=%0d ovf=%b required 1/0/0/0",
               in_ready, sum_valid, sum, overflow);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    in_valid = 1'b0; n_in = '0; mode_in = 1'b0; sum_ready = 1'b1;
    in_valid_b = 1'b0; n_b = '0; mode_b = 1'b0; sum_ready_b = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || sum !== 12'd0 || sum_valid !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: in_ready=%b sum=%0d valid=%b ovf=%b busy=%b required 1/0/0/0/0",
               in_ready, sum, sum_valid, overflow, busy);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_square_n4;
    issue(4, 1);
    finish_result(0);
  endtask

  task automatic test_n15;
    issue(15, 0);
    finish_result(0);
    issue(15, 1);
    finish_result(0);
  endtask

  task automatic test_n_zero;
    issue(0, 0);
    finish_result(0);
    issue(0, 1);
    finish_result(0);
  endtask

  task automatic test_narrow_overflow;
    int     ns[2];
    int     ms[2];
    longint exact;
    logic [7:0] e_sum;
    logic   e_ovf;
    int     len, k;
    ns[0] = 15; ms[0] = 1;
    ns[1] = 15; ms[1] = 0;
    for (int t = 0; t < 2; t++) begin
      exact = exact_sum(ns[t], ms[t]);
      e_ovf = (exact > 255);
      e_sum = 8'(fit_sum(exact, 8));
      len   = (ms[t] == 1) ? ns[t] * (ns[t] + 1) / 2 : ns[t];
      in_valid_b = 1'b1; n_b = 4'(ns[t]); mode_b = ms[t][0];
      @(negedge clk);
      in_valid_b = 1'b0;
      k = 1;
      while (sum_valid_b !== 1'b1 && k <= len + 4) begin
        @(negedge clk);
        k++;
      end
      n_checks++;
      if (sum_valid_b !== 1'b1 || k != len + 1 || sum_b !== e_sum || overflow_b !== e_ovf) begin
        n_fail++;
        $display("FAIL narrow m=%0d: valid=%b cycles=%0d sum=%0d ovf=%b required 1/%0d/%0d/%b",
                 ms[t], sum_valid_b, k, sum_b, overflow_b, len + 1, e_sum, e_ovf);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_pressure;
    sum_ready = 1'b0;
    issue(5, 1);
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      n_in = 4'd2;
      mode_in = 1'b0;
      @(negedge clk);
      n_checks++;
      if (sum_valid !== 1'b1 || sum !== exp_sum || overflow !== exp_ovf || in_ready !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure c=%0d: valid=%b sum=%0d ovf=%b in_ready=%b busy=%b required 1/%0d/%b/0/0",
                 c, sum_valid, sum, overflow, in_ready, busy, exp_sum, exp_ovf);
      end
    end
    in_valid = 1'b1;
    sum_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || sum_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: in_ready=%b busy=%b valid=%b required 1/0/0",
               in_ready, busy, sum_valid);
    end
    issue(2, 0);
    finish_result(0);
  endtask

  task automatic test_reset_mid_acc;
    issue_start: begin
      in_valid = 1'b1; n_in = 4'd9; mode_in = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
    end
    repeat (11) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_acc_busy: busy=%b required 1", busy);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || sum !== 12'd0 || sum_valid !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: in_ready=%b sum=%0d valid=%b ovf=%b busy=%b required 1/0/0/0/0",
               in_ready, sum, sum_valid, overflow, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(3, 1);
    finish_result(0);
  endtask

  task automatic test_random;
    int n, m, d;
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(0, 15);
      m = $urandom_range(0, 1);
      d = $urandom_range(0, 3);
      sum_ready = (d == 0);
      issue(n, m);
      finish_result(d);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_square_n4();
    test_n15();
    test_n_zero();
    test_narrow_overflow();
    test_back_pressure();
    test_reset_mid_acc();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
